// File: rtl/rs_fifo_reg_pkg.sv
// Shared defaults for the rs_fifo_reg register slice.
//   RS_DEFAULT_WIDTH  : default payload width in bits
//   RS_DEFAULT_ENABLE : default slice mode (1 = registered skid buffer)
package rs_fifo_reg_pkg;

  localparam int unsigned RS_DEFAULT_WIDTH  = 32;
  localparam int unsigned RS_DEFAULT_ENABLE = 1;

endpackage : rs_fifo_reg_pkg

// File: rtl/rs_fifo_reg.sv
// Valid/ready register slice. ENABLE_REG=1 builds a 2-entry skid buffer
// whose handshake outputs come straight from flops; ENABLE_REG=0 is a wire.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   if_write   : upstream offers if_din
//   if_din     : upstream data
//   if_full_n  : slice can accept a word (upstream ready)
//   if_empty_n : slice holds a valid word (downstream valid)
//   if_read    : downstream accepts if_dout
//   if_dout    : downstream data (output register)
module rs_fifo_reg
  import rs_fifo_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RS_DEFAULT_WIDTH,
  parameter int unsigned ENABLE_REG = RS_DEFAULT_ENABLE,
  parameter string       __REGION   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  // Floorplan tag only; carries no logic.
  if (__REGION != "") begin : g_region_tag
  end

  if (ENABLE_REG != 0) begin : g_reg

    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  wr_fire;
    logic                  rd_fire;

    // Handshakes qualify on the registered flags, never on each other.
    assign wr_fire = if_write & full_n_q;
    assign rd_fire = if_read  & empty_n_q;

    // State, data and flag registers; flags are updated alongside the state.
    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= EMPTY;
        out_q     <= '0;
        skid_q    <= '0;
        full_n_q  <= 1'b1;
        empty_n_q <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (wr_fire) begin
              out_q     <= if_din;
              state     <= ONE;
              empty_n_q <= 1'b1;
            end
          end
          ONE: begin
            if (wr_fire && rd_fire) begin
              out_q <= if_din;
            end else if (wr_fire) begin
              // Downstream stalled: park the new word behind OUT.
              skid_q   <= if_din;
              state    <= TWO;
              full_n_q <= 1'b0;
            end else if (rd_fire) begin
              state     <= EMPTY;
              empty_n_q <= 1'b0;
            end
          end
          TWO: begin
            // Writes are blocked here since full_n is low.
            if (rd_fire) begin
              out_q    <= skid_q;
              state    <= ONE;
              full_n_q <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
          end
        endcase
      end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_dout    = out_q;

  end else begin : g_comb

    // Pure pass-through; clock and reset are intentionally unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset};

    assign if_full_n  = if_read;
    assign if_empty_n = if_write;
    assign if_dout    = if_din;

  end

endmodule : rs_fifo_reg

// File: tb/tb_rs_fifo_reg.sv
// Self-checking bench for rs_fifo_reg: queue-based reference model for the
// registered slice, plus a pass-through instance checked in the same cycle.
module tb_rs_fifo_reg;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         if_write = 1'b0;
  logic         if_read = 1'b0;
  logic [W-1:0] if_din = '0;
  logic         if_full_n, if_empty_n;
  logic [W-1:0] if_dout;
  logic         c_full_n, c_empty_n;
  logic [W-1:0] c_dout;

  int errors = 0;
  int checks = 0;

  rs_fifo_reg #(.DATA_WIDTH(W), .ENABLE_REG(1), .__REGION("slr0")) u_dut (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_empty_n(if_empty_n), .if_read(if_read),
    .if_dout(if_dout)
  );

  rs_fifo_reg #(.DATA_WIDTH(W), .ENABLE_REG(0)) u_comb (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din),
    .if_full_n(c_full_n), .if_empty_n(c_empty_n), .if_read(if_read),
    .if_dout(c_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the slice is an ordered store of at most two words.
  logic [W-1:0] mq[$];
  bit           model_ok = 1'b0;
  bit           just_reset = 1'b0;

  always begin : compare
    bit aw, ar;
    @(posedge clk);
    just_reset = 1'b0;
    if (reset) begin
      mq.delete();
      model_ok   = 1'b1;
      just_reset = 1'b1;
    end else if (model_ok) begin
      aw = if_write && (mq.size() < 2);
      ar = if_read && (mq.size() > 0);
      if (ar) void'(mq.pop_front());
      if (aw) mq.push_back(if_din);
    end
    #1;
    if (model_ok) begin
      check("model_full_n", W'(if_full_n), W'(mq.size() < 2));
      check("model_empty_n", W'(if_empty_n), W'(mq.size() > 0));
      if (mq.size() > 0) check("model_dout", if_dout, mq[0]);
      if (just_reset) check("reset_dout", if_dout, '0);
    end
  end

  // Drive inputs on the falling edge; registered flags must not move with
  // them, while the pass-through must follow them at once.
  task automatic drive(input logic rst, input logic w, input logic r, input logic [W-1:0] d);
    logic fn, en;
    @(negedge clk);
    fn = if_full_n;
    en = if_empty_n;
    reset = rst;
    if_write = w;
    if_read = r;
    if_din = d;
    #1;
    check("full_n_no_comb_path", W'(if_full_n), W'(fn));
    check("empty_n_no_comb_path", W'(if_empty_n), W'(en));
    check("comb_full_n", W'(c_full_n), W'(r));
    check("comb_empty_n", W'(c_empty_n), W'(w));
    check("comb_dout", c_dout, d);
  endtask

  // Wait until the outputs reflect the next rising edge.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset with handshakes active: they must be ignored.
    do_reset();
    settle();
    check("rst_empty_n", W'(if_empty_n), 0);
    check("rst_full_n", W'(if_full_n), 1);
    check("rst_dout", if_dout, 0);

    // Single word, 1-cycle latency.
    drive(1'b0, 1'b1, 1'b0, 32'hA5);
    settle();
    check("lat_empty_n", W'(if_empty_n), 1);
    check("lat_dout", if_dout, 32'hA5);
    check("lat_full_n", W'(if_full_n), 1);

    // Fill to two, third write dropped, drain in order.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h01);
    settle();
    drive(1'b0, 1'b1, 1'b0, 32'h02);
    settle();
    check("fill_full_n", W'(if_full_n), 0);
    check("fill_dout", if_dout, 32'h01);
    drive(1'b0, 1'b1, 1'b0, 32'h03);
    settle();
    check("drop_full_n", W'(if_full_n), 0);
    check("drop_dout", if_dout, 32'h01);
    drive(1'b0, 1'b0, 1'b1, '0);
    settle();
    check("drain1_dout", if_dout, 32'h02);
    check("drain1_empty_n", W'(if_empty_n), 1);
    check("drain1_full_n", W'(if_full_n), 1);
    drive(1'b0, 1'b0, 1'b1, '0);
    settle();
    check("drain2_empty_n", W'(if_empty_n), 0);

    // Streaming: one word per cycle, one cycle behind the input.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      drive(1'b0, 1'b1, 1'b1, W'(i));
      settle();
      check("stream_dout", if_dout, W'(i));
      check("stream_empty_n", W'(if_empty_n), 1);
    end
    drive(1'b0, 1'b0, 1'b1, '0);

    // Reset while holding two words discards both.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h11);
    drive(1'b0, 1'b1, 1'b0, 32'h22);
    settle();
    check("two_full_n", W'(if_full_n), 0);
    drive(1'b1, 1'b1, 1'b1, 32'h33);
    settle();
    check("midrst_empty_n", W'(if_empty_n), 0);
    check("midrst_full_n", W'(if_full_n), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, '0);
      settle();
      check("midrst_no_emit", W'(if_empty_n), 0);
    end

    // Pass-through pinned with literals.
    drive(1'b0, 1'b1, 1'b0, 32'h5A);
    check("comb_lit_full_n", W'(c_full_n), 0);
    check("comb_lit_empty_n", W'(c_empty_n), 1);
    check("comb_lit_dout", c_dout, 32'h5A);

    // Random traffic with varying write/read pressure.
    for (int i = 0; i < 10000; i++) begin
      int unsigned wp, rp;
      wp = (i / 2500) + 1;
      rp = 4 - (i / 2500);
      drive(1'b0, logic'($urandom_range(0, 4) < wp), logic'($urandom_range(0, 4) < rp), $urandom());
    end

    drive(1'b0, 1'b0, 1'b0, '0);
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rs_fifo_reg

// File: doc/rs_fifo_reg.md
RS_FIFO_REG -- requirements
Module: rs_fifo_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (>=1).
REQ-002 The block SHALL have parameter ENABLE_REG, default 1: 1 = registered slice, 0 = combinational pass-through.
REQ-003 The block SHALL have parameter __REGION, default "" (string): a floorplan tag with no functional effect.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_write  in  1  upstream offers data
- if_din  in  DATA_WIDTH  upstream data
- if_full_n  out  1  slice can accept (upstream ready)
- if_empty_n  out  1  slice holds valid data (downstream valid)
- if_read  in  1  downstream accepts
- if_dout  out  DATA_WIDTH  downstream data

Function
REQ-006 Write handshake: a word SHALL be accepted only on a cycle where if_write=1 and if_full_n=1; if_write with if_full_n=0 SHALL have no effect.
REQ-007 Read handshake: a word SHALL be consumed only on a cycle where if_read=1 and if_empty_n=1; if_read with if_empty_n=0 SHALL have no effect.
REQ-008 ENABLE_REG=0: if_full_n=if_read, if_empty_n=if_write, if_dout=if_din (purely combinational, no state, clk/reset unused).
REQ-009 ENABLE_REG=1: the block SHALL be a 2-entry skid buffer (output register OUT, skid register SKID) with state EMPTY, ONE or TWO.
REQ-010 ENABLE_REG=1: if_empty_n SHALL be 1 in ONE/TWO, and if_full_n SHALL be 1 in EMPTY/ONE; both SHALL be driven from flops with no combinational path from any input.
REQ-011 if_dout SHALL equal OUT.
REQ-012 State transitions SHALL be:
- EMPTY+write -> ONE, OUT<=din
- ONE+write only -> TWO, SKID<=din
- ONE+read only -> EMPTY
- ONE+write+read -> ONE, OUT<=din
- TWO+read -> ONE, OUT<=SKID
- all other cases hold state.
REQ-013 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on if_dout with if_empty_n=1 in the cycle after edge N, provided the slice was empty.
REQ-014 Sustained throughput SHALL be one word per cycle when if_read is held 1.
REQ-015 Words SHALL be delivered in order, with none lost or duplicated.
REQ-016 When empty, if_dout SHALL hold its last value; this value is don't-care.

Reset
REQ-017 While reset=1, the state SHALL go to EMPTY, OUT and SKID SHALL clear to 0, if_empty_n SHALL be 0 and if_full_n SHALL be 1 on the following cycle; handshakes in the reset cycle SHALL be ignored.
REQ-018 Reset asserted mid-operation SHALL discard all held words.

Structure
REQ-019 The block SHALL be a single module with a generate branch on ENABLE_REG; no sub-module.
REQ-020 State encoding SHALL be local parameters (EMPTY=0, ONE=1, TWO=2); no shared package is needed.

Verification
REQ-021 Reset, then write 0xA5 with if_read=0 -> next cycle if_empty_n=1 and if_dout=0xA5; if_full_n stays 1.
REQ-022 if_read=0, write 0x01 then 0x02 -> if_full_n=0 after the second write; a third write 0x03 is dropped; reads return 0x01 then 0x02, then if_empty_n=0.
REQ-023 if_write=1 and if_read=1 continuously with data 1..100 -> if_dout 1..100 on consecutive cycles, one cycle behind input.
REQ-024 Random if_write/if_read over 10k cycles -> output sequence equals input sequence, and if_full_n/if_empty_n never toggle combinationally with inputs.
REQ-025 Fill to TWO, assert reset -> next cycle if_empty_n=0 and if_full_n=1, and prior data is never emitted.
REQ-026 ENABLE_REG=0 -> outputs follow inputs in the same cycle, e.g. if_read=0 gives if_full_n=0.
